// File: rtl/cnn_conv_engine.sv
// 3x3 valid convolution of an 8x8 signed 32-bit image into a 6x6 feature map,
// using one sequential multiply-accumulate unit (one kernel tap per cycle).
module cnn_conv_engine #(
  parameter logic [287:0]       KERNEL = {9{32'h0000_0001}},
  parameter logic signed [31:0] BIAS   = 32'sd0,
  parameter int                 RELU   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2047:0] input_ram,
  output logic          busy,
  output logic          done,
  output logic [1151:0] output_ram
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2047:0]        pix_q, pix_d;
  logic [1151:0]        out_q, out_d;
  logic signed [63:0]   acc_q, acc_d;
  logic [5:0]           o_q, o_d;
  logic [2:0]           r_q, r_d, c_q, c_d;
  logic [1:0]           i_q, i_d, j_q, j_d;

  logic [5:0]           pix_addr;
  logic [3:0]           tap;
  logic [31:0]          pix_word, tap_word;
  logic signed [63:0]   pix_ext, tap_ext, prod;
  logic signed [63:0]   y_full, y_relu;
  logic [31:0]          y_sat;

  // Window position (r+i, c+j) and tap index i*3+j feed the single multiplier.
  assign pix_addr = ({3'b000, r_q} + {4'b0000, i_q}) * 6'd8 + {3'b000, c_q} + {4'b0000, j_q};
  assign tap      = {2'b00, i_q} * 4'd3 + {2'b00, j_q};
  assign pix_word = pix_q[{pix_addr, 5'b00000} +: 32];
  assign tap_word = KERNEL[{tap, 5'b00000} +: 32];
  assign pix_ext  = {{32{pix_word[31]}}, pix_word};
  assign tap_ext  = {{32{tap_word[31]}}, tap_word};
  assign prod     = pix_ext * tap_ext;

  // Bias, optional ReLU, then clamp the 64-bit sum into the 32-bit result range.
  always_comb begin
    y_full = acc_q + {{32{BIAS[31]}}, BIAS};
    y_relu = y_full;
    if (RELU != 0 && y_full < 64'sd0) y_relu = 64'sd0;
    if (y_relu > 64'sd2147483647)       y_sat = 32'h7FFF_FFFF;
    else if (y_relu < -64'sd2147483648) y_sat = 32'h8000_0000;
    else                                y_sat = y_relu[31:0];
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pix_d   = pix_q;
    out_d   = out_q;
    acc_d   = acc_q;
    o_d     = o_q;
    r_d     = r_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        pix_d   = input_ram;
        acc_d   = 64'sd0;
        o_d     = 6'd0;
        r_d     = 3'd0;
        c_d     = 3'd0;
        i_d     = 2'd0;
        j_d     = 2'd0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (j_q == 2'd2) begin
          j_d = 2'd0;
          if (i_q == 2'd2) begin
            i_d     = 2'd0;
            state_d = WRITE;
          end else begin
            i_d = i_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      WRITE: begin
        out_d[{o_q, 5'b00000} +: 32] = y_sat;
        acc_d = 64'sd0;
        i_d   = 2'd0;
        j_d   = 2'd0;
        if (o_q == 6'd35) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          o_d     = o_q + 6'd1;
          state_d = MAC;
          if (c_q == 3'd5) begin
            c_d = 3'd0;
            r_d = r_q + 3'd1;
          end else begin
            c_d = c_q + 3'd1;
          end
        end
      end
      DONE: begin
        // Dropping start is the only way back, so a held start never retriggers.
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
      out_q   <= '0;
      acc_q   <= 64'sd0;
      o_q     <= 6'd0;
      r_q     <= 3'd0;
      c_q     <= 3'd0;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      r_q     <= r_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign output_ram = out_q;

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboard bench for cnn_conv_engine: four parameter variants share one
// stimulus; expected words are queued at start and popped at each write edge.
module tb_cnn_conv_engine;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2047:0] input_ram;
  logic          busy_w [4];
  logic          done_w [4];
  logic [1151:0] out_w  [4];

  int            pix [64];
  logic [31:0]   sb_q [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  cnn_conv_engine dut0 (
    .clk(clk), .rst(rst), .start(start), .input_ram(input_ram),
    .busy(busy_w[0]), .done(done_w[0]), .output_ram(out_w[0])
  );

  cnn_conv_engine #(.RELU(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .input_ram(input_ram),
    .busy(busy_w[1]), .done(done_w[1]), .output_ram(out_w[1])
  );

  cnn_conv_engine #(.RELU(0), .BIAS(32'sd50)) dut2 (
    .clk(clk), .rst(rst), .start(start), .input_ram(input_ram),
    .busy(busy_w[2]), .done(done_w[2]), .output_ram(out_w[2])
  );

  // Weights k-4 for tap k, so tap order and sign handling both matter.
  cnn_conv_engine #(
    .RELU(0),
    .KERNEL({32'sd4, 32'sd3, 32'sd2, 32'sd1, 32'sd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC})
  ) dut3 (
    .clk(clk), .rst(rst), .start(start), .input_ram(input_ram),
    .busy(busy_w[3]), .done(done_w[3]), .output_ram(out_w[3])
  );

  function automatic longint weightOf(int sel, int k);
    return (sel == 3) ? longint'(k - 4) : 64'sd1;
  endfunction

  function automatic logic [31:0] modelWord(int sel, int o);
    longint sum;
    int r, c;
    r   = o / 6;
    c   = o % 6;
    sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += longint'(pix[(r + i) * 8 + c + j]) * weightOf(sel, i * 3 + j);
    if (sel == 2) sum += 50;
    if (sel == 0 && sum < 0) sum = 0;
    if (sum > 64'sd2147483647) sum = 64'sd2147483647;
    if (sum < -64'sd2147483648) sum = -64'sd2147483648;
    return sum[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives a pixel pattern, fills the scoreboard, and raises start.
  task automatic applyStimulus(input int mode);
    int v;
    for (int p = 0; p < 64; p++) begin
      case (mode)
        0:       v = 1;
        1:       v = p;
        2:       v = -5;
        3:       v = 32'h7FFF_FFFF;
        4:       v = 32'h8000_0000;
        default: v = int'($urandom_range(0, 2000)) - 1000;
      endcase
      pix[p] = v;
      input_ram[p * 32 +: 32] = v;
    end
    sb_q.delete();
    for (int o = 0; o < 36; o++)
      for (int sel = 0; sel < 4; sel++)
        sb_q.push_back(modelWord(sel, o));
    start = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int sel = 0; sel < 4; sel++)
      checkOutput($sformatf("%s_d%0d", tag, sel), {63'b0, |out_w[sel]}, 64'd0);
  endtask

  // Walks edges 1..361 after the start edge, comparing at each write edge.
  task automatic runConv(input string name, input int change_at, input int rst_at);
    int o;
    @(posedge clk);
    for (int n = 1; n <= 361; n++) begin
      @(posedge clk);
      #1;
      if (n == change_at) input_ram = ~input_ram;
      if (n == 1) begin
        checkOutput({name, "_busy_load"}, {63'b0, busy_w[0]}, 64'd1);
        checkOutput({name, "_done_load"}, {63'b0, done_w[0]}, 64'd0);
      end
      if (n == rst_at - 1) rst = 1'b1;
      if (n == rst_at) begin
        checkOutput({name, "_rst_busy"}, {63'b0, busy_w[0]}, 64'd0);
        checkOutput({name, "_rst_done"}, {63'b0, done_w[0]}, 64'd0);
        checkAllZero({name, "_rst_out"});
        rst   = 1'b0;
        start = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, "_post_rst_busy"}, {63'b0, busy_w[0]}, 64'd0);
        return;
      end
      if (n >= 11 && (n - 11) % 10 == 0) begin
        o = (n - 11) / 10;
        for (int sel = 0; sel < 4; sel++) begin
          if (sb_q.size() == 0) begin
            checkOutput($sformatf("%s_sb_empty_o%0d", name, o), 64'd0, 64'd1);
          end else begin
            checkOutput($sformatf("%s_out%0d_d%0d", name, o, sel),
                        {32'b0, out_w[sel][o * 32 +: 32]}, {32'b0, sb_q.pop_front()});
          end
        end
      end
      if (n == 360) begin
        checkOutput({name, "_done_360"}, {63'b0, done_w[0]}, 64'd0);
        checkOutput({name, "_busy_360"}, {63'b0, busy_w[0]}, 64'd1);
      end
      if (n == 361) begin
        checkOutput({name, "_done_361"}, {63'b0, done_w[0]}, 64'd1);
        checkOutput({name, "_busy_361"}, {63'b0, busy_w[0]}, 64'd0);
      end
    end
    checkOutput({name, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_done_hold"}, {63'b0, done_w[0]}, 64'd1);
    checkOutput({name, "_no_retrigger"}, {63'b0, busy_w[0]}, 64'd0);
  endtask

  task automatic dropStart(input string name);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "_done_fall"}, {63'b0, done_w[0]}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput({name, "_idle_busy"}, {63'b0, busy_w[0]}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    input_ram = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {63'b0, busy_w[0]}, 64'd0);
    checkOutput("reset_done", {63'b0, done_w[0]}, 64'd0);
    checkAllZero("reset_out");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0); runConv("ones", 0, 0); dropStart("ones");

    applyStimulus(1); runConv("ramp", 0, 0);
    checkOutput("ramp_out0",  {32'b0, out_w[0][0 +: 32]},       64'd81);
    checkOutput("ramp_out5",  {32'b0, out_w[0][5 * 32 +: 32]},  64'd126);
    checkOutput("ramp_out35", {32'b0, out_w[0][35 * 32 +: 32]}, 64'd486);
    dropStart("ramp");

    applyStimulus(2); runConv("neg5", 0, 0);
    checkOutput("neg5_relu",  {32'b0, out_w[0][7 * 32 +: 32]}, 64'd0);
    checkOutput("neg5_plain", {32'b0, out_w[1][7 * 32 +: 32]}, 64'hFFFF_FFD3);
    checkOutput("neg5_bias",  {32'b0, out_w[2][7 * 32 +: 32]}, 64'd5);
    dropStart("neg5");

    applyStimulus(3); runConv("satpos", 0, 0); dropStart("satpos");
    applyStimulus(4); runConv("satneg", 0, 0);
    checkOutput("satneg_plain", {32'b0, out_w[1][0 +: 32]}, 64'h8000_0000);
    dropStart("satneg");

    applyStimulus(5); runConv("snap", 50, 0); dropStart("snap");

    applyStimulus(1); runConv("abort", 0, 100);
    @(negedge clk);
    applyStimulus(5); runConv("rerun", 0, 0); dropStart("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_conv_engine.md
Name: cnn_conv_engine

Overview:
- First stage of the CNN pipeline: 3x3 valid convolution of an 8x8 image of signed 32-bit pixels, producing a 6x6 feature map (36 words).
- Result feeds the 2x2 pooling stage.
- Uses one sequential multiply-accumulate unit: one tap per cycle, start/done handshake.

Parameters:
- KERNEL, default 288'h all taps = 32'sd1, nine signed 32-bit weights; tap k = i*3+j (row i, col j) at bits [32k+31:32k].
- BIAS, default 0, signed 32-bit value added to every output.
- RELU, default 1; 1 clamps negative results to 0, 0 passes them through.

Ports:
- clk  in  1  clock; rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level request to run a convolution.
- input_ram  in  2048  64 signed 32-bit pixels; pixel p = row*8+col at bits [32p+31:32p].
- busy  out  1  high from the run's first cycle through the final write.
- done  out  1  high while the engine is in DONE.
- output_ram  out  1152  36 signed 32-bit results; output o = r*6+c at bits [32o+31:32o].

Behaviour:
- States: IDLE, LOAD, MAC, WRITE, DONE.
- Reset (synchronous): state IDLE; done=0, busy=0; all output_ram words=0; accumulator and counters cleared.
- Reset mid-run: abandons the run. No done pulse; outputs cleared.
- IDLE: start=1 at an edge -> LOAD; busy=1 from that edge on. start=0 -> stay in IDLE.
- LOAD (1 cycle):
  - Snapshots input_ram into an internal 64-word buffer; input changes after this edge do not affect the run.
  - Clears the accumulator, sets output index o=0 and tap k=0, then -> MAC.
- MAC (9 cycles per output):
  - Each edge: acc += pix[(r+i)*8+(c+j)] * KERNEL[k], with k=i*3+j, k=0..8, r=o/6, c=o%6.
  - Cross-correlation: the kernel is not flipped.
  - After k=8 -> WRITE.
- Arithmetic: full 64-bit signed product and 64-bit signed accumulator. No intermediate truncation.
- WRITE (1 cycle):
  - y = acc + BIAS.
  - If RELU=1 and y<0, then y=0.
  - Saturate y to the signed 32-bit range [-2^31, 2^31-1].
  - Store y to output word o; clear acc, k=0.
  - If o<35: o++ and -> MAC. Otherwise -> DONE.
- Output words update as they are written. Words not yet written in a run keep their previous values.
- Latency: with the start-sampling edge as edge 0:
  - LOAD at edge 1.
  - Output o is written at edge 11+10*o.
  - Final write and done=1 at edge 361; busy=0 at the same edge.
- DONE:
  - done stays high and output_ram holds while start=1.
  - start=0 -> IDLE, with done=0 at that edge.
  - A new run requires start to pass through 0. Holding start high never retriggers.
- start is ignored outside IDLE and DONE.

Test Plan:
- Default params, all pixels = 1, start held high -> every output = 9; done rises exactly at edge 361; done stays high until start drops, then falls on the next edge.
- Ramp input, pixel p = p, default params -> out[o] = 9*((r+1)*8+(c+1)); out0=81, out5=126, out35=486; out0 written at edge 11.
- All pixels = -5: RELU=1 -> all outputs 0; RELU=0 -> all outputs -45; BIAS=50 with RELU=0 -> all outputs 5.
- All pixels = 32'h7FFFFFFF -> all outputs saturate to 32'h7FFFFFFF. With RELU=0 and pixels = 32'h80000000, all outputs saturate to 32'h80000000.
- Change input_ram after LOAD (e.g., at edge 50) -> results match the snapshot taken at edge 1, not the new data.
- Assert rst at edge 100 mid-run -> done=0, busy=0, all outputs 0 on the next cycle. A subsequent start gives a complete, correct run with done at edge 361 relative to the new start.
